// File: rtl/iir_in_pacer.sv
// iir_in_pacer: small sample FIFO feeding an IIR filter with strobes spaced
// at least GAP clk cycles apart.
// Optional build macro PACER_STATS_EN adds emit_cnt and the sticky underrun flag.
`timescale 1ns/1ps
module iir_in_pacer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAP        = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [23:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [23:0]                   m_data,
  output logic                          m_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PACER_STATS_EN
  ,
  output logic [15:0]                   emit_cnt,
  output logic                          underrun
`endif
);

  localparam int unsigned DW = 24;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = 4;

  typedef enum logic [0:0] {S_IDLE, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic            push_c, pop_c;
  logic            m_valid_d;
  logic [DW-1:0]   m_data_d;

  // s_ready is a flop, so the handshake depends only on registered state
  assign push_c     = s_valid && s_ready;
  assign level_d    = level_q + LW'(push_c) - LW'(pop_c);
  assign fifo_level = level_q;

  // Emitter next-state: pop and strobe from IDLE, then hold off GAP cycles
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    pop_c     = 1'b0;
    m_valid_d = 1'b0;
    m_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop_c     = 1'b1;
          m_valid_d = 1'b1;
          m_data_d  = mem[rd_ptr_q];
          gap_d     = GW'(GAP - 1);
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q <= GW'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        gap_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Emitter state, gap counter and registered strobe/data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      m_valid <= m_valid_d;
      m_data  <= m_data_d;
    end
  end

  // FIFO pointers, occupancy and registered ready (pointers wrap naturally)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      s_ready  <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      s_ready <= (level_d != LW'(FIFO_DEPTH));
    end
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= s_data;
  end

`ifdef PACER_STATS_EN
  // Strobe counter and sticky underrun on a gap ending with nothing queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emit_cnt <= '0;
      underrun <= 1'b0;
    end else begin
      if (m_valid_d) emit_cnt <= emit_cnt + 16'(1);
      if (state_q == S_GAP && state_d == S_IDLE && level_q == '0) underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iir_in_pacer.sv
// Directed bench for iir_in_pacer: reset, latency, burst, full FIFO, mid-run reset.
`timescale 1ns/1ps
module tb_iir_in_pacer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] m_data;
  logic        m_valid;
  logic [3:0]  fifo_level;
`ifdef PACER_STATS_EN
  logic [15:0] emit_cnt;
  logic        underrun;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_nz = 0;
  logic [23:0] sq[$];
  int          tq[$];

  iir_in_pacer #(.FIFO_DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .fifo_level (fifo_level)
`ifdef PACER_STATS_EN
    ,
    .emit_cnt   (emit_cnt),
    .underrun   (underrun)
`endif
  );

  always #3 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe logger and idle-data watcher
  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      sq.push_back(m_data);
      tq.push_back(cyc);
    end else if (m_data !== 24'd0) begin
      idle_nz++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %0b want 0", m_valid); end
    checks++; if (m_data !== 24'd0) begin errors++; $display("FAIL rst_m_data got %h want 0", m_data); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %0b want 0", s_ready); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    tick(3);
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got %0b want 0", s_ready); end
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %0b want 1", s_ready); end
  endtask

  task automatic test_single;
    tick(2);
    sq.delete(); tq.delete();
    @(negedge clk); s_valid = 1'b1; s_data = 24'h7FFFFF;
    @(negedge clk); s_valid = 1'b0; s_data = '0;
    checks++; if (fifo_level !== 4'd1 || m_valid !== 1'b0) begin errors++; $display("FAIL single_wr level %0d valid %0b want 1/0", fifo_level, m_valid); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 24'h7FFFFF) begin errors++; $display("FAIL single_strobe valid %0b data %h want 1/7fffff", m_valid, m_data); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_pop_level got %0d want 0", fifo_level); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || m_data !== 24'd0) begin errors++; $display("FAIL single_after valid %0b data %h want 0/0", m_valid, m_data); end
    tick(15);
    checks++; if (sq.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", sq.size()); end
  endtask

  task automatic test_burst;
    int max_lvl = 0;
    int drop = 0;
    int bad_val = 0;
    int bad_gap = 0;
    tick(15);
    sq.delete(); tq.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b1) drop++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      s_valid = 1'b1; s_data = 24'(i + 1);
    end
    @(negedge clk); s_valid = 1'b0; s_data = '0;
    for (int t = 0; t < 200 && sq.size() < 8; t++) begin
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      @(negedge clk);
    end
    checks++; if (max_lvl != 7) begin errors++; $display("FAIL burst_max_level got %0d want 7", max_lvl); end
    checks++; if (drop != 0) begin errors++; $display("FAIL burst_ready_drop got %0d want 0", drop); end
    checks++; if (sq.size() != 8) begin errors++; $display("FAIL burst_count got %0d want 8", sq.size()); end
    for (int i = 0; i < sq.size(); i++) if (sq[i] !== 24'(i + 1)) bad_val++;
    for (int i = 1; i < tq.size(); i++) if (tq[i] - tq[i-1] != int'(GAP)) bad_gap++;
    checks++; if (bad_val != 0) begin errors++; $display("FAIL burst_order got %0d bad values want 0", bad_val); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL burst_spacing got %0d bad gaps want 0", bad_gap); end
  endtask

  task automatic test_full;
    logic [23:0] v [12] = '{24'h800000, 24'h000001, 24'hFFFFFF, 24'h7FFFFF,
                            24'h123456, 24'hABCDEF, 24'h800001, 24'h00FF00,
                            24'h555555, 24'hAAAAAA, 24'h0F0F0F, 24'hF0F0F0};
    int idx = 0;
    int seen_full = 0;
    int ready_bad = 0;
    int bad_val = 0;
    int bad_gap = 0;
    logic hs;
    tick(15);
    sq.delete(); tq.delete();
    for (int t = 0; t < 400 && sq.size() < 12; t++) begin
      @(negedge clk);
      if (fifo_level == 4'd8) seen_full++;
      if (s_ready !== (fifo_level != 4'd8)) ready_bad++;
      if (idx < 12) begin s_valid = 1'b1; s_data = v[idx]; end
      else begin s_valid = 1'b0; s_data = '0; end
      hs = s_ready && (idx < 12);
      @(posedge clk);
      if (hs) idx++;
    end
    @(negedge clk); s_valid = 1'b0;
    checks++; if (seen_full == 0) begin errors++; $display("FAIL full_reached got 0 full cycles want >0"); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL full_ready got %0d bad cycles want 0", ready_bad); end
    checks++; if (sq.size() != 12) begin errors++; $display("FAIL full_count got %0d want 12", sq.size()); end
    for (int i = 0; i < sq.size() && i < 12; i++) if (sq[i] !== v[i]) bad_val++;
    for (int i = 1; i < tq.size(); i++) if (tq[i] - tq[i-1] != int'(GAP)) bad_gap++;
    checks++; if (bad_val != 0) begin errors++; $display("FAIL full_values got %0d bad values want 0", bad_val); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL full_spacing got %0d bad gaps want 0", bad_gap); end
  endtask

  task automatic test_mid_reset;
    tick(15);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); s_valid = 1'b1; s_data = 24'h300000 + 24'(i);
    end
    @(negedge clk); s_valid = 1'b0; s_data = '0;
    @(posedge clk); #1;
    checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL mrst_pre_level got %0d want 5", fifo_level); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 24'd0) begin errors++; $display("FAIL mrst_out valid %0b data %h want 0/0", m_valid, m_data); end
    checks++; if (fifo_level !== 4'd0 || s_ready !== 1'b0) begin errors++; $display("FAIL mrst_fifo level %0d ready %0b want 0/0", fifo_level, s_ready); end
    tick(3);
    sq.delete(); tq.delete();
    rst_n = 1'b1;
    tick(30);
    checks++; if (sq.size() != 0) begin errors++; $display("FAIL mrst_stale got %0d strobes want 0", sq.size()); end
    @(negedge clk); s_valid = 1'b1; s_data = 24'h800000;
    @(negedge clk); s_valid = 1'b0; s_data = '0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mrst_early got %0b want 0", m_valid); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 24'h800000) begin errors++; $display("FAIL mrst_latency valid %0b data %h want 1/800000", m_valid, m_data); end
    tick(15);
  endtask

`ifdef PACER_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    #1;
    checks++; if (emit_cnt !== 16'd0 || underrun !== 1'b0) begin errors++; $display("FAIL stats_rst cnt %0d un %0b want 0/0", emit_cnt, underrun); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_valid = 1'b1; s_data = 24'(i + 5);
      @(negedge clk); s_valid = 1'b0;
      tick(8);
    end
    tick(40);
    @(negedge clk); s_valid = 1'b1; s_data = 24'h000042;
    @(negedge clk); s_valid = 1'b0;
    tick(15);
    checks++; if (emit_cnt !== 16'd4) begin errors++; $display("FAIL stats_cnt got %0d want 4", emit_cnt); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL stats_underrun got %0b want 1", underrun); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    test_reset;
    test_single;
    test_burst;
    test_full;
    test_mid_reset;
`ifdef PACER_STATS_EN
    test_stats;
`endif
    checks++; if (idle_nz != 0) begin errors++; $display("FAIL idle_data got %0d nonzero idle cycles want 0", idle_nz); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
